// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_defs: shared encodings for mem_port_arbiter
// Holds the FSM state codes, bus size codes and the owner codes (0 = inst, 1 = data).
package mem_arb_defs;
  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_ADDR = 2'd1;
  localparam logic [1:0] ARB_DATA = 2'd2;
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;
endpackage

// File: rtl/mem_port_arbiter_pick.sv
// arb_pick: combinational winner selection between the inst and data requesters
// Ports: inst_req/data_req in, last_owner in (only with MEM_ARB_RR_EN),
// grant_inst/grant_data out (at most one high, each implies its request).
module arb_pick
  import mem_arb_defs::*;
(
`ifdef MEM_ARB_RR_EN
  input  logic last_owner,
`endif
  input  logic inst_req,
  input  logic data_req,
  output logic grant_inst,
  output logic grant_data
);
`ifdef MEM_ARB_RR_EN
  // On contention the requester that lost last time goes first.
  assign grant_data = data_req & ~(inst_req & (last_owner == OWN_DATA));
`else
  assign grant_data = data_req;
`endif
  assign grant_inst = inst_req & ~grant_data;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one SRAM-like bus port between fetch and mem-stage requesters
// Ports: clk/rst, flush_except; inst_* request/response; data_* request/response;
// bus_* latched request out and handshake/response in; i_stall/d_stall levels.
// Optional MEM_ARB_RR_EN: round-robin on contention via a last_owner register.
module mem_port_arbiter
  import mem_arb_defs::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_except,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [3:0]        data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [3:0]        bus_wstrb,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              i_stall,
  output logic              d_stall
);
  logic [1:0] state_q, state_d;
  logic owner_q, owner_d, cancel_q, cancel_d;
  logic bus_wr_q, bus_wr_d;
  logic [1:0] bus_size_q, bus_size_d;
  logic [3:0] bus_wstrb_q, bus_wstrb_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic idle, addr_st, data_st, load, resp, grant_inst, grant_data;
`ifdef MEM_ARB_RR_EN
  logic last_owner_q, last_owner_d;
`endif
  assign idle    = state_q == ARB_IDLE;
  assign addr_st = state_q == ARB_ADDR;
  assign data_st = state_q == ARB_DATA;
  arb_pick u_pick (
`ifdef MEM_ARB_RR_EN
    .last_owner (last_owner_q),
`endif
    .inst_req   (inst_req),
    .data_req   (data_req),
    .grant_inst (grant_inst),
    .grant_data (grant_data)
  );
  assign load = idle & (inst_req | data_req);
  // bus_data_ok is only meaningful once the address phase has finished.
  assign resp = data_st & bus_data_ok;
  assign inst_addr_ok = idle & grant_inst;
  assign data_addr_ok = idle & grant_data;
  // A flush arriving on the response cycle suppresses the return just like a stored cancel.
  assign inst_data_ok = resp & (owner_q == OWN_INST) & ~cancel_q & ~flush_except;
  assign data_data_ok = resp & (owner_q == OWN_DATA);
  assign inst_rdata = bus_rdata;
  assign data_rdata = bus_rdata;
  assign bus_req   = addr_st;
  assign bus_wr    = bus_wr_q;
  assign bus_size  = bus_size_q;
  assign bus_wstrb = bus_wstrb_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign i_stall = (inst_req & ~inst_addr_ok) | ((owner_q == OWN_INST) & ~idle & ~inst_data_ok);
  assign d_stall = (data_req & ~data_addr_ok) | ((owner_q == OWN_DATA) & ~idle & ~data_data_ok);
  always_comb begin
    state_d = idle ? (load ? ARB_ADDR : ARB_IDLE)
            : addr_st ? (bus_addr_ok ? ARB_DATA : ARB_ADDR)
            : (data_st & ~bus_data_ok) ? ARB_DATA : ARB_IDLE;
    owner_d = load ? grant_data : owner_q;
    cancel_d = resp ? 1'b0
             : cancel_q | (flush_except & (addr_st | data_st) & (owner_q == OWN_INST));
    bus_wr_d    = load ? (grant_data & data_wr) : bus_wr_q;
    bus_size_d  = load ? (grant_data ? data_size : SIZE_WORD) : bus_size_q;
    bus_wstrb_d = load ? (grant_data ? data_wstrb : 4'd0) : bus_wstrb_q;
    bus_addr_d  = load ? (grant_data ? data_addr : inst_addr) : bus_addr_q;
    bus_wdata_d = load ? (grant_data ? data_wdata : '0) : bus_wdata_q;
`ifdef MEM_ARB_RR_EN
    last_owner_d = load ? grant_data : last_owner_q;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      owner_q     <= OWN_INST;
      cancel_q    <= 1'b0;
      bus_wr_q    <= 1'b0;
      bus_size_q  <= 2'd0;
      bus_wstrb_q <= 4'd0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
`ifdef MEM_ARB_RR_EN
      last_owner_q <= OWN_INST;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cancel_q    <= cancel_d;
      bus_wr_q    <= bus_wr_d;
      bus_size_q  <= bus_size_d;
      bus_wstrb_q <= bus_wstrb_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
`ifdef MEM_ARB_RR_EN
      last_owner_q <= last_owner_d;
`endif
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random checks of mem_port_arbiter against a transaction-level model
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1, flush_except = 1'b0, inst_req = 1'b0, data_req = 1'b0, data_wr = 1'b0;
  logic bus_addr_ok = 1'b0, bus_data_ok = 1'b0;
  logic [AW-1:0] inst_addr = '0, data_addr = '0;
  logic [1:0] data_size = 2'd2;
  logic [3:0] data_wstrb = 4'd0;
  logic [DW-1:0] data_wdata = '0, bus_rdata = '0;
  logic inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, bus_req, bus_wr, i_stall, d_stall;
  logic [DW-1:0] inst_rdata, data_rdata, bus_wdata;
  logic [1:0] bus_size;
  logic [3:0] bus_wstrb;
  logic [AW-1:0] bus_addr;
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .flush_except(flush_except),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_wstrb(bus_wstrb),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok),
    .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata), .i_stall(i_stall), .d_stall(d_stall)
  );
  int n_chk = 0, n_fail = 0;
  // Model: one outstanding transaction record plus the last winner.
  bit m_busy = 0, m_onbus = 0, m_own_data = 0, m_cancel = 0, m_last_data = 0;
  logic m_wr;
  logic [1:0] m_size;
  logic [3:0] m_wstrb;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  bit e_iaok, e_daok;
  logic o_iaok, o_daok, o_idok, o_ddok, o_breq, o_istall, o_dstall, o_bwr;
  logic [3:0] o_bwstrb;
  logic [AW-1:0] o_baddr;
  logic [DW-1:0] o_bwdata, o_irdata, o_drdata;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    bit wd, rsp, e_idok, e_ddok, e_is, e_ds;
    #2;
    wd = data_req && !(RR && inst_req && m_last_data);
    e_daok = !m_busy && wd;
    e_iaok = !m_busy && inst_req && !wd;
    rsp = m_busy && m_onbus && bus_data_ok;
    e_idok = rsp && !m_own_data && !m_cancel && !flush_except;
    e_ddok = rsp && m_own_data;
    e_is = (inst_req && !e_iaok) || (m_busy && !m_own_data && !e_idok);
    e_ds = (data_req && !e_daok) || (m_busy && m_own_data && !e_ddok);
    o_iaok = inst_addr_ok; o_daok = data_addr_ok; o_idok = inst_data_ok; o_ddok = data_data_ok;
    o_breq = bus_req; o_istall = i_stall; o_dstall = d_stall; o_bwr = bus_wr;
    o_bwstrb = bus_wstrb; o_baddr = bus_addr; o_bwdata = bus_wdata;
    o_irdata = inst_rdata; o_drdata = data_rdata;
    chk("inst_addr_ok", o_iaok, e_iaok);
    chk("data_addr_ok", o_daok, e_daok);
    chk("inst_data_ok", o_idok, e_idok);
    chk("data_data_ok", o_ddok, e_ddok);
    chk("bus_req", o_breq, m_busy && !m_onbus);
    chk("i_stall", o_istall, e_is);
    chk("d_stall", o_dstall, e_ds);
    chk("inst_rdata", o_irdata, bus_rdata);
    chk("data_rdata", o_drdata, bus_rdata);
    if (m_busy) begin
      chk("bus_wr", o_bwr, m_wr);
      chk("bus_size", bus_size, m_size);
      chk("bus_wstrb", o_bwstrb, m_wstrb);
      chk("bus_addr", o_baddr, m_addr);
      chk("bus_wdata", o_bwdata, m_wdata);
    end
    if (rst) begin
      m_busy = 0; m_onbus = 0; m_cancel = 0; m_last_data = 0; m_own_data = 0;
    end else if (!m_busy) begin
      if (e_iaok || e_daok) begin
        m_busy = 1; m_onbus = 0; m_own_data = e_daok; m_last_data = e_daok;
        m_wr = e_daok && data_wr;
        m_size = e_daok ? data_size : 2'd2;
        m_wstrb = e_daok ? data_wstrb : 4'd0;
        m_addr = e_daok ? data_addr : inst_addr;
        m_wdata = e_daok ? data_wdata : '0;
      end
    end else begin
      if (flush_except && !m_own_data) m_cancel = 1;
      if (!m_onbus) m_onbus = bus_addr_ok;
      else if (bus_data_ok) begin m_busy = 0; m_cancel = 0; end
    end
    @(posedge clk); #1;
  endtask
  task automatic drain();
    int n = 0;
    while ((m_busy || inst_req || data_req) && n < 60) begin
      bus_addr_ok = m_busy && !m_onbus;
      bus_data_ok = m_busy && m_onbus;
      bus_rdata = $urandom;
      step();
      if (e_iaok) inst_req = 0;
      if (e_daok) data_req = 0;
      n++;
    end
    bus_addr_ok = 0; bus_data_ok = 0;
    chk("drain_bound", n < 60, 1);
  endtask
  initial begin
    @(posedge clk); #1;
    step(); step();
    rst = 0; step();
    chk("rst_bus_req", o_breq, 0); chk("rst_i_stall", o_istall, 0);
    chk("rst_d_stall", o_dstall, 0); chk("rst_iaok", o_iaok, 0);
    // single fetch
    inst_req = 1; inst_addr = 32'hBFC00000; step(); chk("fetch_aok_c0", o_iaok, 1);
    inst_req = 0; bus_addr_ok = 1; step();
    chk("fetch_breq_c1", o_breq, 1); chk("fetch_baddr", o_baddr, 32'hBFC00000);
    bus_addr_ok = 0; step(); chk("fetch_stall_c2", o_istall, 1); chk("fetch_dok_c2", o_idok, 0);
    bus_data_ok = 1; bus_rdata = 32'h3C08BFC0; step();
    chk("fetch_dok_c3", o_idok, 1); chk("fetch_rdata", o_irdata, 32'h3C08BFC0);
    chk("fetch_stall_c3", o_istall, 0);
    bus_data_ok = 0;
    // simultaneous: data first, inst one cycle after data_data_ok
    data_req = 1; data_wr = 0; data_size = 2; data_addr = 32'h80000010;
    inst_req = 1; inst_addr = 32'hBFC00004; step();
    chk("cont_daok", o_daok, 1); chk("cont_iaok", o_iaok, 0); chk("cont_istall", o_istall, 1);
    data_req = 0; bus_addr_ok = 1; step();
    bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h12345678; step();
    chk("cont_ddok", o_ddok, 1); chk("cont_drdata", o_drdata, 32'h12345678);
    bus_data_ok = 0; step(); chk("cont_inst_next", o_iaok, 1); chk("cont_inst_baddr_pending", o_breq, 0);
    inst_req = 0; drain();
    // second contention right after a data win: round robin hands it to inst
    data_req = 1; data_addr = 32'h80000018; inst_req = 1; inst_addr = 32'hBFC00010; step();
    data_req = 0; bus_addr_ok = 1; step();
    bus_addr_ok = 0; bus_data_ok = 1; step();
    bus_data_ok = 0; data_req = 1; data_wr = 1; data_addr = 32'h80000014; data_wstrb = 4'hF; data_wdata = 32'h55;
    step(); chk("cont2_iaok", o_iaok, RR); chk("cont2_daok", o_daok, !RR);
    if (e_iaok) inst_req = 0;
    if (e_daok) data_req = 0;
    drain();
    // store with a 4-cycle address delay
    data_req = 1; data_wr = 1; data_size = 2; data_wstrb = 4'b0011; data_wdata = 32'h0000ABCD;
    data_addr = 32'h80000020; step(); chk("st_daok", o_daok, 1);
    data_req = 0;
    repeat (4) begin
      step();
      chk("st_breq", o_breq, 1); chk("st_bwr", o_bwr, 1);
      chk("st_bwstrb", o_bwstrb, 4'b0011); chk("st_bwdata", o_bwdata, 32'h0000ABCD);
    end
    bus_addr_ok = 1; step(); bus_addr_ok = 0; bus_data_ok = 1; step();
    chk("st_ddok", o_ddok, 1); bus_data_ok = 0; data_wr = 0;
    // flush during DATA of an inst transaction
    inst_req = 1; inst_addr = 32'hBFC00008; step(); inst_req = 0;
    bus_addr_ok = 1; step(); bus_addr_ok = 0;
    flush_except = 1; step(); chk("fl_dok_a", o_idok, 0); flush_except = 0;
    bus_data_ok = 1; bus_rdata = 32'hDEAD0001; step(); chk("fl_dok_b", o_idok, 0); bus_data_ok = 0;
    inst_req = 1; inst_addr = 32'hBFC0000C; step(); chk("fl_next_aok", o_iaok, 1); inst_req = 0;
    bus_addr_ok = 1; step(); bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h00001111; step();
    chk("fl_next_dok", o_idok, 1); chk("fl_next_rdata", o_irdata, 32'h00001111); bus_data_ok = 0;
    // flush landing on the response cycle
    inst_req = 1; step(); inst_req = 0; bus_addr_ok = 1; step(); bus_addr_ok = 0;
    bus_data_ok = 1; flush_except = 1; step(); chk("fl_same_cycle", o_idok, 0);
    bus_data_ok = 0; flush_except = 0;
    // reset while in ADDR
    inst_req = 1; inst_addr = 32'hBFC00020; step(); inst_req = 0;
    rst = 1; step(); chk("rm_breq_addr", o_breq, 1);
    rst = 0; bus_data_ok = 1; step();
    chk("rm_breq", o_breq, 0); chk("rm_idok", o_idok, 0); chk("rm_istall", o_istall, 0);
    bus_data_ok = 0;
    // back-pressure: 10 cycles without bus_addr_ok
    inst_req = 1; inst_addr = 32'hBFC00030; data_req = 1; data_wr = 0; data_addr = 32'h80000040; step();
    data_req = 0;
    repeat (10) begin
      step();
      chk("bp_breq", o_breq, 1); chk("bp_baddr", o_baddr, 32'h80000040);
      chk("bp_istall", o_istall, 1); chk("bp_dstall", o_dstall, 1);
    end
    drain();
    // random traffic
    repeat (800) begin
      if (!inst_req && $urandom_range(0, 2) == 0) begin
        inst_req = 1; inst_addr = $urandom & 32'hFFFFFFFC;
      end
      if (!data_req && $urandom_range(0, 2) == 0) begin
        data_req = 1; data_wr = 1'($urandom); data_size = 2'($urandom_range(0, 2));
        data_wstrb = 4'($urandom); data_addr = $urandom; data_wdata = $urandom;
      end
      bus_addr_ok = m_busy && !m_onbus && ($urandom_range(0, 2) == 0);
      bus_data_ok = m_busy && m_onbus && ($urandom_range(0, 2) == 0);
      bus_rdata = $urandom;
      flush_except = $urandom_range(0, 7) == 0;
      step();
      if (e_iaok) inst_req = 0;
      if (e_daok) data_req = 0;
    end
    flush_except = 0;
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
